// File: rtl/c4_pkg.sv
// Shared constants and types for the Connect Four move-entry logic.
//   NUM_COLS / NUM_ROWS : board geometry (7 columns, 6 tokens per column)
//   IDLE_COL            : drop-bus value that selects no column
//   drop_state_t        : drop sequencing states
//   get_count()         : extracts one 3-bit column count from the packed bus
package c4_pkg;

   localparam int NUM_COLS = 7;
   localparam int NUM_ROWS = 6;
   localparam logic [3:0] IDLE_COL = 4'hF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      SETTLE = 2'd2
   } drop_state_t;

   // An out-of-range column reads back as all ones, so it is treated as full
   // and can never receive a drop.
   function automatic logic [2:0] get_count(input logic [3*NUM_COLS-1:0] bus,
                                            input logic [3:0] col);
      logic [2:0] r;
      r = 3'b111;
      for (int i = 0; i < NUM_COLS; i++) begin
         if (col == 4'(i)) begin
            r = bus[3*i +: 3];
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/drop_issuer_key_edge.sv
// Rising-edge detector for one already-synchronized key level.
//   clk     : system clock
//   reset   : synchronous active-low reset; history is forced to 1 so a key
//             held through reset does not register as a press
//   level_i : key level
//   pulse_o : high in the cycle where level_i is 1 and was 0 one cycle earlier
module key_edge (
   input  logic clk,
   input  logic reset,
   input  logic level_i,
   output logic pulse_o
);

   logic hist_q;
   logic hist_d;

   // History follows the key every cycle, independent of the consumer's state.
   always_comb begin
      hist_d = level_i;
   end

   // History register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         hist_q <= 1'b1;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign pulse_o = level_i & ~hist_q;

endmodule

// File: rtl/drop_issuer.sv
// Move-entry controller: turns key presses into single-cycle column drops.
//   clk, reset  : system clock, synchronous active-low reset
//   key_left    : move cursor left (rising edge)
//   key_right   : move cursor right (rising edge)
//   key_drop    : drop a token in the cursor column (rising edge)
//   game_over   : while high, key presses are ignored
//   counts      : packed per-column token counts, column c at [3c+2:3c]
//   inputcolumn : registered drop bus, IDLE_COL except for one cycle per drop
//   cursor      : selected column
//   player      : side to move
//   drop_ack    : one-cycle pulse when a drop completes and the turn passes
//   reject      : one-cycle pulse when a drop targets a full column
module drop_issuer
   import c4_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  key_left,
   input  logic                  key_right,
   input  logic                  key_drop,
   input  logic                  game_over,
   input  logic [3*NUM_COLS-1:0] counts,
   output logic [3:0]            inputcolumn,
   output logic [3:0]            cursor,
   output logic                  player,
   output logic                  drop_ack,
   output logic                  reject
);

   logic left_p;
   logic right_p;
   logic drop_p;
   logic col_full;

   drop_state_t state_q, state_d;
   logic [3:0]  cursor_q, cursor_d;
   logic        player_q, player_d;
   logic [3:0]  inputcolumn_q, inputcolumn_d;
   logic        drop_ack_q, drop_ack_d;
   logic        reject_q, reject_d;

   key_edge u_edge_left  (.clk(clk), .reset(reset), .level_i(key_left),  .pulse_o(left_p));
   key_edge u_edge_right (.clk(clk), .reset(reset), .level_i(key_right), .pulse_o(right_p));
   key_edge u_edge_drop  (.clk(clk), .reset(reset), .level_i(key_drop),  .pulse_o(drop_p));

   // Oversized counts also count as full.
   assign col_full = (get_count(counts, cursor_q) >= 3'(NUM_ROWS));

   // Next-state and output decode; the bus defaults back to IDLE_COL so it is
   // driven with a column for exactly the one cycle following acceptance.
   always_comb begin
      state_d       = state_q;
      cursor_d      = cursor_q;
      player_d      = player_q;
      inputcolumn_d = IDLE_COL;
      drop_ack_d    = 1'b0;
      reject_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!game_over) begin
               if (drop_p) begin
                  // Drop wins over any simultaneous move.
                  if (col_full) begin
                     reject_d = 1'b1;
                  end else begin
                     inputcolumn_d = cursor_q;
                     state_d       = ISSUE;
                  end
               end else if (left_p && !right_p) begin
                  if (cursor_q == 4'd0) begin
                     cursor_d = 4'(NUM_COLS - 1);
                  end else begin
                     cursor_d = cursor_q - 4'd1;
                  end
               end else if (right_p && !left_p) begin
                  if (cursor_q >= 4'(NUM_COLS - 1)) begin
                     cursor_d = 4'd0;
                  end else begin
                     cursor_d = cursor_q + 4'd1;
                  end
               end else begin
                  cursor_d = cursor_q;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            // The counter increment is visible by now, so the next full check
            // in IDLE sees it.
            player_d   = ~player_q;
            drop_ack_d = 1'b1;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         cursor_q      <= 4'd3;
         player_q      <= 1'b0;
         inputcolumn_q <= IDLE_COL;
         drop_ack_q    <= 1'b0;
         reject_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         cursor_q      <= cursor_d;
         player_q      <= player_d;
         inputcolumn_q <= inputcolumn_d;
         drop_ack_q    <= drop_ack_d;
         reject_q      <= reject_d;
      end
   end

   assign inputcolumn = inputcolumn_q;
   assign cursor      = cursor_q;
   assign player      = player_q;
   assign drop_ack    = drop_ack_q;
   assign reject      = reject_q;

endmodule

// File: tb/tb_drop_issuer.sv
module tb_drop_issuer;
   import c4_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  reset_n;
   logic                  key_left, key_right, key_drop, game_over;
   logic [3*NUM_COLS-1:0] counts;
   logic [3:0]            inputcolumn, cursor;
   logic                  player, drop_ack, reject;

   drop_issuer dut (
      .clk(clk), .reset(reset_n), .key_left(key_left), .key_right(key_right),
      .key_drop(key_drop), .game_over(game_over), .counts(counts),
      .inputcolumn(inputcolumn), .cursor(cursor), .player(player),
      .drop_ack(drop_ack), .reject(reject)
   );

   int checks = 0;
   int failures = 0;
   int edge_cnt = 0;

   // Board-side row counters, driven by the DUT's bus (they share reset).
   int cnt[NUM_COLS];
   // Reference counts predicted from accepted drops.
   int ref_cnt[NUM_COLS];

   // kind: 0 = issue (val = column), 1 = ack (val = new player), 2 = reject
   typedef struct { int kind; int val; int at; } ev_t;
   ev_t exp_q[$];

   // Reference model state.
   int   m_cursor = 3;
   int   m_player = 0;
   int   ready_at = 0;
   int   toggle_at = -1;
   logic p_l = 1'b1, p_r = 1'b1, p_d = 1'b1;

   always_comb begin
      counts = '0;
      for (int c = 0; c < NUM_COLS; c++) counts[3*c +: 3] = 3'(cnt[c]);
   end

   always @(posedge clk) begin
      edge_cnt <= edge_cnt + 1;
      for (int c = 0; c < NUM_COLS; c++) begin
         if (!reset_n) cnt[c] <= 0;
         else if (inputcolumn == 4'(c)) cnt[c] <= cnt[c] + 1;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic take(input int kind, input int val);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL unexpected_event kind=%0d val=%0d at edge %0d, none required", kind, val, edge_cnt);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val != val || e.at != edge_cnt) begin
            failures++;
            $display("FAIL event actual kind=%0d val=%0d edge=%0d required kind=%0d val=%0d edge=%0d",
                     kind, val, edge_cnt, e.kind, e.val, e.at);
         end
      end
   endtask

   // Monitor: every visible output event must match the queue head.
   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].at < edge_cnt) begin
         checks++;
         failures++;
         $display("FAIL missing_event kind=%0d val=%0d actual=absent required_edge=%0d",
                  exp_q[0].kind, exp_q[0].val, exp_q[0].at);
         void'(exp_q.pop_front());
      end
      if (inputcolumn != IDLE_COL) take(0, int'(inputcolumn));
      if (drop_ack) take(1, int'(player));
      if (reject) take(2, 0);
   end

   // Reference model for the edge about to happen (edge number n).
   task automatic model(input logic rs, input logic l, input logic r, input logic d, input logic go);
      int   n;
      logic el, er, ed;
      n = edge_cnt + 1;
      if (!rs) begin
         p_l = 1'b1; p_r = 1'b1; p_d = 1'b1;
         m_cursor = 3; m_player = 0; ready_at = n + 1; toggle_at = -1;
         for (int c = 0; c < NUM_COLS; c++) ref_cnt[c] = 0;
         while (exp_q.size() > 0 && exp_q[$].at >= n) void'(exp_q.pop_back());
      end else begin
         if (toggle_at == n) m_player = 1 - m_player;
         el = l && !p_l; er = r && !p_r; ed = d && !p_d;
         if (n >= ready_at && !go) begin
            if (ed) begin
               if (ref_cnt[m_cursor] >= NUM_ROWS) begin
                  exp_q.push_back('{2, 0, n});
               end else begin
                  exp_q.push_back('{0, m_cursor, n});
                  exp_q.push_back('{1, 1 - m_player, n + 2});
                  ref_cnt[m_cursor]++;
                  toggle_at = n + 2;
                  ready_at  = n + 3;
               end
            end else if (el && !er) begin
               m_cursor = (m_cursor + NUM_COLS - 1) % NUM_COLS;
            end else if (er && !el) begin
               m_cursor = (m_cursor + 1) % NUM_COLS;
            end
         end
         p_l = l; p_r = r; p_d = d;
      end
   endtask

   // One clock: drive at negedge, predict, check state after the edge.
   task automatic step(input logic rs, input logic l, input logic r, input logic d, input logic go);
      reset_n = rs; key_left = l; key_right = r; key_drop = d; game_over = go;
      model(rs, l, r, d, go);
      @(posedge clk);
      #1;
      chk("cursor", int'(cursor), m_cursor);
      chk("player", int'(player), m_player);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk_counts(input string name);
      for (int c = 0; c < NUM_COLS; c++) chk(name, cnt[c], ref_cnt[c]);
   endtask

   initial begin
      reset_n = 1'b0; key_left = 1'b0; key_right = 1'b0; key_drop = 1'b1; game_over = 1'b0;
      @(negedge clk);

      // Reset with drop held, then release reset while still held.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("reset_inputcolumn", int'(inputcolumn), 15);
      chk("reset_drop_ack", int'(drop_ack), 0);
      chk("reset_reject", int'(reject), 0);
      chk("reset_cursor", int'(cursor), 3);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Cursor wrap in both directions, and simultaneous left+right.
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         idle(1);
      end
      chk("cursor_wrap_right", int'(cursor), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(1);
      chk("cursor_wrap_left", int'(cursor), 6);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(1);
      chk("cursor_both", int'(cursor), 6);

      // Single drop into column 2.
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         idle(1);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(4);
      chk_counts("count_after_col2");
      chk("col2_count", cnt[2], 1);
      chk("player_after_first_drop", int'(player), 1);

      // Fill column 0, seventh drop is rejected.
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
         idle(1);
      end
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         idle(3);
      end
      chk("col0_full", cnt[0], 6);
      chk("player_after_fill", int'(player), 1);

      // Move key pressed during ISSUE is dropped.
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(4);
      chk("cursor_after_issue_move", int'(cursor), 1);

      // game_over blocks keys; game_over during a drop does not abort it.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(2);
      chk_counts("count_after_game_over");

      // Reset in the ISSUE cycle cancels the drop.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("abort_inputcolumn", int'(inputcolumn), 15);
      idle(4);
      chk("abort_player", int'(player), 0);
      chk_counts("count_after_abort");

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         step(1'($urandom_range(0, 199) != 0),
              1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 15) == 0));
      end
      idle(6);
      chk("queue_drained", exp_q.size(), 0);
      chk_counts("count_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
